// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router datapath: byte width, header
// field positions and destination address encodings.
package router_pkg;

    localparam int DATA_W   = 8;

    // Header byte layout: [1:0] destination, [7:2] payload length
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    typedef enum logic [1:0] {
        ADDR_FIFO0 = 2'b00,
        ADDR_FIFO1 = 2'b01,
        ADDR_FIFO2 = 2'b10
    } dest_addr_e;

    // Payload length carried in a header byte
    function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR accumulator with synchronous clear and enable. Kept separate
// so a CRC variant can reuse the same clear/enable interface.
module router_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    // Clear has priority over accumulation so a new packet always starts from zero
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router. Driven by the control FSM's
// state strobes, it steers bytes to the FIFO write port, parks a byte
// while the FIFO is full, accumulates packet parity and flags mismatches.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pkt_vld,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_vld,
    output logic              err,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hdr_byte;
    logic [DATA_W-1:0] full_byte;
    logic [DATA_W-1:0] int_parity;
    logic [DATA_W-1:0] pkt_parity;

    logic              acc_en;
    logic [DATA_W-1:0] acc_din;

    // Header is counted during load_first_data; payload bytes only while the source
    // flags them valid, so the parity byte itself never enters the sum. A byte
    // parked because the FIFO is full was already counted in load_data.
    always_comb begin
        acc_en  = lfd_state || (ld_state && pkt_vld);
        acc_din = lfd_state ? hdr_byte : data_in;
    end

    router_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity_acc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (detect_add),
        .en   (acc_en),
        .din  (acc_din),
        .acc  (int_parity)
    );

    // Capture the header byte while the FSM decodes the destination address
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_byte <= '0;
        end else if (detect_add && pkt_vld) begin
            hdr_byte <= data_in;
        end
    end

    // FIFO write data: header first, then payload; a byte arriving while the FIFO
    // is full is parked in full_byte and replayed in load_after_full
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout      <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            dout <= hdr_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    // Source has dropped pkt_vld for this packet; only the parity check state clears it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            low_pkt_vld <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_vld <= 1'b0;
        end else if (ld_state && !pkt_vld) begin
            low_pkt_vld <= 1'b1;
        end
    end

    // Latch the received parity byte, either directly or after a full-FIFO replay
    always_ff @(posedge clk) begin
        if (!rstn) begin
            parity_done <= 1'b0;
            pkt_parity  <= '0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !pkt_vld) begin
            parity_done <= 1'b1;
            pkt_parity  <= data_in;
        end else if (laf_state && low_pkt_vld && !parity_done) begin
            parity_done <= 1'b1;
            pkt_parity  <= full_byte;
        end
    end

    // Sticky parity error, compared once the received parity byte is in hand
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done && (int_parity != pkt_parity)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: emulates the control FSM strobe
// sequence per packet and compares against a packet-level reference model.
module tb_router_reg;
    import router_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              pkt_vld;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              full_state;
    logic              laf_state;
    logic              rst_int_reg;
    logic              parity_done;
    logic              low_pkt_vld;
    logic              err;
    logic [DATA_W-1:0] dout;

    int checks = 0;
    int errors = 0;

    // Reference state: payload bytes of the packet being sent, and whether
    // low_pkt_vld is expected to be pending from an earlier packet
    logic [7:0] pay [0:63];
    logic       exp_low;

    router_reg #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pkt_vld     (pkt_vld),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .full_state  (full_state),
        .laf_state   (laf_state),
        .rst_int_reg (rst_int_reg),
        .parity_done (parity_done),
        .low_pkt_vld (low_pkt_vld),
        .err         (err),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        pkt_vld     = 1'b0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        full_state  = 1'b0;
        laf_state   = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one packet through the FSM strobe sequence.
    // stall_at: -1 no stall, 0..len-1 stall on that payload byte, len stall on parity byte.
    task automatic send_packet(input logic [7:0] hdr, input int len, input int stall_at,
                               input int nfull, input logic bad, input logic do_rst,
                               input string tag);
        logic [7:0] x;
        logic [7:0] par;
        logic [7:0] last;
        logic       exp_err;
        x = hdr;
        for (int i = 0; i < len; i++) x = x ^ pay[i];
        par     = bad ? (x ^ 8'h01) : x;
        exp_err = (x != par);
        last    = hdr;

        // decode_address
        idle_inputs();
        detect_add = 1'b1; pkt_vld = 1'b1; data_in = hdr;
        tick();
        checks++;
        if (err !== 1'b0 || parity_done !== 1'b0 || low_pkt_vld !== exp_low) begin
            errors++;
            $display("FAIL %s detect: err=%b pd=%b low=%b want err=0 pd=0 low=%b",
                     tag, err, parity_done, low_pkt_vld, exp_low);
        end

        // load_first_data
        detect_add = 1'b0; lfd_state = 1'b1; data_in = pay[0];
        tick();
        checks++;
        if (dout !== hdr) begin
            errors++;
            $display("FAIL %s hdr dout got %h want %h", tag, dout, hdr);
        end
        lfd_state = 1'b0;

        // payload
        for (int i = 0; i < len; i++) begin
            ld_state = 1'b1; pkt_vld = 1'b1; data_in = pay[i];
            if (i == stall_at) begin
                fifo_full = 1'b1;
                tick();
                ld_state = 1'b0; full_state = 1'b1;
                repeat (nfull) tick();
                checks++;
                if (dout !== last) begin
                    errors++;
                    $display("FAIL %s full hold dout got %h want %h", tag, dout, last);
                end
                full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
                tick();
                laf_state = 1'b0;
                checks++;
                if (dout !== pay[i]) begin
                    errors++;
                    $display("FAIL %s laf dout got %h want %h", tag, dout, pay[i]);
                end
            end else begin
                fifo_full = 1'b0;
                tick();
                checks++;
                if (dout !== pay[i]) begin
                    errors++;
                    $display("FAIL %s payload[%0d] dout got %h want %h", tag, i, dout, pay[i]);
                end
            end
            last = pay[i];
        end

        // parity byte
        ld_state = 1'b1; pkt_vld = 1'b0; data_in = par;
        if (stall_at == len) begin
            fifo_full = 1'b1;
            tick();
            checks++;
            if (low_pkt_vld !== 1'b1 || parity_done !== 1'b0 || dout !== last) begin
                errors++;
                $display("FAIL %s par stall: low=%b pd=%b dout=%h want low=1 pd=0 dout=%h",
                         tag, low_pkt_vld, parity_done, dout, last);
            end
            ld_state = 1'b0; full_state = 1'b1;
            repeat (nfull) tick();
            checks++;
            if (parity_done !== 1'b0) begin
                errors++;
                $display("FAIL %s par full pd got %b want 0", tag, parity_done);
            end
            full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
            tick();
            laf_state = 1'b0;
            checks++;
            if (parity_done !== 1'b1 || dout !== par) begin
                errors++;
                $display("FAIL %s par laf: pd=%b dout=%h want pd=1 dout=%h",
                         tag, parity_done, dout, par);
            end
        end else begin
            tick();
            checks++;
            if (parity_done !== 1'b1 || low_pkt_vld !== 1'b1 || dout !== par) begin
                errors++;
                $display("FAIL %s parity: pd=%b low=%b dout=%h want pd=1 low=1 dout=%h",
                         tag, parity_done, low_pkt_vld, dout, par);
            end
        end
        exp_low = 1'b1;

        // one cycle later the comparison result appears
        idle_inputs();
        tick();
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err got %b want %b", tag, err, exp_err);
        end
        repeat (2) tick();
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err sticky got %b want %b", tag, err, exp_err);
        end

        // check_parity_error
        if (do_rst) begin
            rst_int_reg = 1'b1;
            tick();
            rst_int_reg = 1'b0;
            checks++;
            if (low_pkt_vld !== 1'b0 || err !== exp_err) begin
                errors++;
                $display("FAIL %s rst_int: low=%b err=%b want low=0 err=%b",
                         tag, low_pkt_vld, err, exp_err);
            end
            exp_low = 1'b0;
        end
    endtask

    task automatic load_std_payload();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    endtask

    task automatic test_reset();
        idle_inputs();
        data_in = 8'hA5;
        rstn = 1'b0;
        repeat (2) tick();
        checks++;
        if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_vld !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%h pd=%b low=%b err=%b want all 0",
                     dout, parity_done, low_pkt_vld, err);
        end
        rstn = 1'b1;
        exp_low = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        load_std_payload();
        send_packet(8'h0D, 3, -1, 0, 1'b0, 1'b1, "normal");
    endtask

    task automatic test_bad_parity();
        load_std_payload();
        send_packet(8'h0D, 3, -1, 0, 1'b1, 1'b1, "bad_parity");
    endtask

    task automatic test_fifo_full_mid();
        load_std_payload();
        send_packet(8'h0D, 3, 1, 3, 1'b0, 1'b1, "full_mid");
    endtask

    task automatic test_parity_full();
        load_std_payload();
        send_packet(8'h0D, 3, 3, 2, 1'b0, 1'b1, "parity_full");
    endtask

    task automatic test_reset_mid();
        load_std_payload();
        // leave err and low_pkt_vld set so the reset has something to clear
        send_packet(8'h0D, 3, -1, 0, 1'b1, 1'b0, "pre_reset");
        idle_inputs();
        detect_add = 1'b1; pkt_vld = 1'b1; data_in = 8'h0D;
        tick();
        detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h11;
        tick();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        checks++;
        if (dout !== 8'h22 || low_pkt_vld !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset state: dout=%h low=%b want dout=22 low=1", dout, low_pkt_vld);
        end
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (dout !== 8'h00 || parity_done !== 1'b0 || low_pkt_vld !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: dout=%h pd=%b low=%b err=%b want all 0",
                     dout, parity_done, low_pkt_vld, err);
        end
        exp_low = 1'b0;
        send_packet(8'h0D, 3, -1, 0, 1'b0, 1'b1, "post_reset");
    endtask

    task automatic test_back_to_back();
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        send_packet({6'd2, ADDR_FIFO2}, 2, -1, 0, 1'b1, 1'b1, "b2b_bad");
        pay[0] = 8'h01; pay[1] = 8'h80; pay[2] = 8'hFF; pay[3] = 8'h7E;
        send_packet({6'd4, ADDR_FIFO0}, 4, -1, 0, 1'b0, 1'b1, "b2b_good");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int         len;
            int         stall;
            int         nfull;
            logic [1:0] addr;
            logic       bad;
            len   = $urandom_range(1, 12);
            addr  = 2'($urandom_range(0, 2));
            bad   = 1'($urandom_range(0, 1));
            nfull = $urandom_range(1, 4);
            stall = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
            send_packet({6'(len), addr}, len, stall, nfull, bad, 1'b1, "random");
        end
    endtask

    initial begin
        idle_inputs();
        data_in = '0;
        rstn    = 1'b0;
        exp_low = 1'b0;
        test_reset();
        test_normal();
        test_bad_parity();
        test_fifo_full_mid();
        test_parity_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
